// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Byte-addressed instruction store with a debug byte loader and a
//   one-cycle-latency word fetch port.
//
//   i_clock, i_reset_n           clock, synchronous active-low reset
//   i_enable                     global enable, all state holds when low
//   i_read_enable, i_read_addr   fetch request, byte address
//   o_read_data                  fetched word, big-endian (lowest address in MSB lane)
//   o_read_valid, o_read_error   good word / misaligned or out-of-range fetch
//   i_load_start                 start a load at byte 0
//   i_load_valid, i_load_last,
//   i_load_byte                  load byte stream
//   o_load_ready                 a byte is accepted this cycle
//   o_load_done                  one-cycle pulse at load completion
//   o_load_count                 bytes written in the current/last load
module instr_mem_loader #(
    parameter int NB_INSTRUCTION = 32,
    parameter int MEMORY_DEPTH   = 1024,
    parameter int NB_ADDR_DEPTH  = 10,
    parameter int NB_ADDR        = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_enable,
    input  logic                      i_read_enable,
    input  logic [NB_ADDR-1:0]        i_read_addr,
    output logic [NB_INSTRUCTION-1:0] o_read_data,
    output logic                      o_read_valid,
    output logic                      o_read_error,
    input  logic                      i_load_start,
    input  logic                      i_load_valid,
    input  logic                      i_load_last,
    input  logic [7:0]                i_load_byte,
    output logic                      o_load_ready,
    output logic                      o_load_done,
    output logic [NB_ADDR_DEPTH:0]    o_load_count
);
    localparam int NUM_LANES   = NB_INSTRUCTION / 8;
    localparam int NB_LANE_SEL = $clog2(NUM_LANES);
    // Highest byte address at which a whole word still fits.
    localparam logic [NB_ADDR-1:0]       MAX_ADDR = NB_ADDR'(MEMORY_DEPTH - NUM_LANES);
    localparam logic [NB_ADDR_DEPTH-1:0] LAST_PTR = '1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                    state, state_next;
    logic [NB_ADDR_DEPTH:0]    load_count, load_count_next;
    logic [NB_ADDR_DEPTH-1:0]  wr_ptr;
    logic                      wr_en;
    logic [NB_INSTRUCTION-1:0] rd_word, rd_data_next;
    logic                      rd_valid_next, rd_error_next;
    logic [NB_ADDR_DEPTH-1:0]  rd_base;
    logic                      misaligned, out_of_range;

    // Contents start at zero and survive reset.
    logic [7:0] mem [MEMORY_DEPTH] = '{default: 8'h00};

    // Pointer and count always move together, so the count's low bits
    // address the write; the load stops before the pointer could wrap.
    assign wr_ptr = load_count[NB_ADDR_DEPTH-1:0];

    assign rd_base      = i_read_addr[NB_ADDR_DEPTH-1:0];
    assign misaligned   = |i_read_addr[NB_LANE_SEL-1:0];
    assign out_of_range = i_read_addr > MAX_ADDR;

    // Lane k carries byte addr+k; lane 0 sits in the MSBs.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [NB_ADDR_DEPTH-1:0] lane_addr;
        assign lane_addr = rd_base + NB_ADDR_DEPTH'(k);
        assign rd_word[NB_INSTRUCTION-1-8*k -: 8] = mem[lane_addr];
    end

    always_comb begin
        state_next      = state;
        load_count_next = load_count;
        wr_en           = 1'b0;
        rd_data_next    = '0;
        rd_valid_next   = 1'b0;
        rd_error_next   = 1'b0;

        // Fetches are only serviced from IDLE; otherwise the port reports a
        // stall (no data, no error). The memory read uses the current
        // contents, so a fetch alongside i_load_start sees pre-load data.
        if (i_read_enable && state == IDLE) begin
            if (misaligned || out_of_range) begin
                rd_error_next = 1'b1;
            end else begin
                rd_data_next  = rd_word;
                rd_valid_next = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (i_load_start) begin
                    state_next      = LOAD;
                    load_count_next = '0;
                end
            end
            LOAD: begin
                if (i_load_valid) begin
                    wr_en           = 1'b1;
                    load_count_next = load_count + 1'b1;
                    if (i_load_last || wr_ptr == LAST_PTR) state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            load_count   <= '0;
            o_read_data  <= '0;
            o_read_valid <= 1'b0;
            o_read_error <= 1'b0;
        end else if (i_enable) begin
            state        <= state_next;
            load_count   <= load_count_next;
            o_read_data  <= rd_data_next;
            o_read_valid <= rd_valid_next;
            o_read_error <= rd_error_next;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset_n && i_enable && wr_en) mem[wr_ptr] <= i_load_byte;
    end

    assign o_load_ready = (state == LOAD) && i_enable;
    assign o_load_done  = (state == DONE);
    assign o_load_count = load_count;
endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;
    localparam int DEPTH = 1024;

    logic        i_clock = 1'b0;
    logic        i_reset_n, i_enable, i_read_enable;
    logic [31:0] i_read_addr;
    logic [31:0] o_read_data;
    logic        o_read_valid, o_read_error;
    logic        i_load_start, i_load_valid, i_load_last;
    logic [7:0]  i_load_byte;
    logic        o_load_ready, o_load_done;
    logic [10:0] o_load_count;

    int n_tests = 0;
    int n_fail  = 0;

    instr_mem_loader dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_enable(i_enable),
        .i_read_enable(i_read_enable), .i_read_addr(i_read_addr),
        .o_read_data(o_read_data), .o_read_valid(o_read_valid),
        .o_read_error(o_read_error), .i_load_start(i_load_start),
        .i_load_valid(i_load_valid), .i_load_last(i_load_last),
        .i_load_byte(i_load_byte), .o_load_ready(o_load_ready),
        .o_load_done(o_load_done), .o_load_count(o_load_count)
    );

    always #5 i_clock = ~i_clock;

    // Reference model: a byte array plus the loader's phase (0 idle,
    // 1 loading, 2 done) and the expected registered fetch outputs.
    logic [7:0]  m_mem [DEPTH];
    int          m_phase, m_count;
    logic [31:0] m_data;
    bit          m_valid, m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_step();
        int a;
        if (!i_reset_n) begin
            m_phase = 0; m_count = 0; m_data = 0; m_valid = 0; m_err = 0;
        end else if (i_enable) begin
            m_data = 0; m_valid = 0; m_err = 0;
            if (i_read_enable && m_phase == 0) begin
                if (i_read_addr % 4 != 0 || i_read_addr > 32'(DEPTH - 4)) m_err = 1;
                else begin
                    a = int'(i_read_addr);
                    m_data  = {m_mem[a], m_mem[a+1], m_mem[a+2], m_mem[a+3]};
                    m_valid = 1;
                end
            end
            case (m_phase)
                0: if (i_load_start) begin m_phase = 1; m_count = 0; end
                1: if (i_load_valid) begin
                       m_mem[m_count] = i_load_byte;
                       m_count++;
                       if (i_load_last || m_count == DEPTH) m_phase = 2;
                   end
                default: m_phase = 0;
            endcase
        end
    endfunction

    task automatic tick();
        @(posedge i_clock);
        model_step();
        #1;
        check("read_data",  o_read_data,  m_data);
        check("read_valid", o_read_valid, m_valid);
        check("read_error", o_read_error, m_err);
        check("load_count", o_load_count, m_count);
        check("load_done",  o_load_done,  m_phase == 2);
        check("load_ready", o_load_ready, m_phase == 1 && i_enable);
    endtask

    task automatic drive(input bit rst_n, input bit en, input bit rd, input logic [31:0] addr,
                         input bit start, input bit lv, input bit last, input logic [7:0] b);
        i_reset_n = rst_n; i_enable = en; i_read_enable = rd; i_read_addr = addr;
        i_load_start = start; i_load_valid = lv; i_load_last = last; i_load_byte = b;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fetch(input logic [31:0] addr);
        drive(1, 1, 1, addr, 0, 0, 0, 0);
    endtask

    initial begin
        logic [7:0] pat [4];
        pat[0] = 8'h12; pat[1] = 8'h34; pat[2] = 8'h56; pat[3] = 8'h78;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        m_phase = 0; m_count = 0; m_data = 0; m_valid = 0; m_err = 0;

        // Reset state, with enable low to show reset overrides it.
        drive(0, 0, 1, 0, 1, 1, 0, 8'hff);
        drive(0, 1, 1, 0, 1, 1, 0, 8'hff);
        check("rst_count", o_load_count, 0);
        check("rst_ready", o_load_ready, 0);

        // Reset aborts a load after two bytes; written bytes stay.
        drive(1, 1, 0, 0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 1, 0, pat[0]);
        drive(1, 1, 0, 0, 0, 1, 0, pat[1]);
        drive(0, 1, 0, 0, 0, 1, 0, pat[2]);
        check("abort_count", o_load_count, 0);
        check("abort_done",  o_load_done,  0);
        fetch(0);
        check("abort_word", o_read_data, 32'h12340000);

        // Four-byte load with last on the fourth byte, then fetch.
        drive(1, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0, 1, i == 3, pat[i]);
        check("load4_done",  o_load_done,  1);
        check("load4_count", o_load_count, 4);
        idle(1);
        fetch(0);
        check("load4_word",  o_read_data,  32'h12345678);
        check("load4_valid", o_read_valid, 1);

        // Misaligned and out-of-range fetches.
        fetch(2);
        check("misalign_err", o_read_error, 1);
        fetch(DEPTH);
        check("oor_err", o_read_error, 1);
        fetch(DEPTH - 4);
        fetch(32'hffff_fffc);
        fetch(DEPTH - 2);

        // Fetch during a load stalls; after completion it returns data.
        drive(1, 1, 1, 0, 1, 0, 0, 0);
        fetch(0);
        check("stall_valid", o_read_valid, 0);
        check("stall_err",   o_read_error, 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 0, 1, i == 3, 8'hA0 + 8'(i));
        fetch(0);
        fetch(0);
        check("after_word", o_read_data, 32'hA0A1A2A3);

        // Enable low for three cycles mid-load freezes everything.
        drive(1, 1, 0, 0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 1, 0, 8'h11);
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 0, 1, 0, 8'hEE);
        check("freeze_count", o_load_count, 1);
        drive(1, 1, 0, 0, 0, 1, 0, 8'h22);
        drive(1, 1, 0, 0, 0, 1, 0, 8'h33);
        drive(1, 1, 0, 0, 0, 1, 1, 8'h44);
        idle(1);
        fetch(0);
        check("freeze_word", o_read_data, 32'h11223344);

        // Full-depth stream without last; extra byte in DONE is ignored.
        drive(1, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) drive(1, 1, 0, 0, 0, 1, 0, 8'($urandom));
        check("full_done",  o_load_done,  1);
        check("full_count", o_load_count, DEPTH);
        drive(1, 1, 0, 0, 0, 1, 0, 8'h5A);
        check("full_extra", o_load_count, DEPTH);
        fetch(DEPTH - 4);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            logic [31:0] addr;
            case ($urandom_range(0, 3))
                0:       addr = $urandom;
                1:       addr = 32'(DEPTH - 8 + $urandom_range(0, 15));
                default: addr = 32'($urandom_range(0, 63)) & ~32'h3;
            endcase
            drive($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 1) == 1, addr, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
